// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing for the VGA timing generator and the renderer.
// Timing constants, counter-width helpers and the idle sync/de level live here.
package vga_pkg;

  localparam int unsigned H_PIXELS_DEF      = 640;
  localparam int unsigned H_FRONT_PORCH_DEF = 16;
  localparam int unsigned H_SYNC_PULSE_DEF  = 96;
  localparam int unsigned H_BACK_PORCH_DEF  = 48;
  localparam int unsigned V_PIXELS_DEF      = 480;
  localparam int unsigned V_FRONT_PORCH_DEF = 10;
  localparam int unsigned V_SYNC_PULSE_DEF  = 2;
  localparam int unsigned V_BACK_PORCH_DEF  = 33;
  localparam bit          SYNC_ACTIVE_LOW_DEF = 1'b1;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  function automatic int unsigned total4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

  // Deasserted sync (polarity-aware) and no display enable.
  function automatic sync_t sync_idle(input bit active_low);
    sync_t s;
    s.hsync = active_low;
    s.vsync = active_low;
    s.de    = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// ce-gated shift register for {hsync, vsync, de}; resets every stage to the idle level.
// DEPTH = 0 degenerates to a wire that still shows the idle level while reset is held.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH           = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  ce_i,
  input  sync_t d_i,
  output sync_t q_o
);

  localparam sync_t IDLE = sync_idle(SYNC_ACTIVE_LOW);

  if (DEPTH == 0) begin : g_wire
    assign q_o = rst_i ? IDLE : d_i;
  end else begin : g_shift
    sync_t [DEPTH-1:0] stage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stage_q <= {DEPTH{IDLE}};
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Raster counters, strobes and frame count for the VGA path, with hsync/vsync/de
// delayed by SYNC_DELAY pixel steps to match the renderer's registered colour.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_PIXELS        = H_PIXELS_DEF,
  parameter int unsigned H_FRONT_PORCH   = H_FRONT_PORCH_DEF,
  parameter int unsigned H_SYNC_PULSE    = H_SYNC_PULSE_DEF,
  parameter int unsigned H_BACK_PORCH    = H_BACK_PORCH_DEF,
  parameter int unsigned V_PIXELS        = V_PIXELS_DEF,
  parameter int unsigned V_FRONT_PORCH   = V_FRONT_PORCH_DEF,
  parameter int unsigned V_SYNC_PULSE    = V_SYNC_PULSE_DEF,
  parameter int unsigned V_BACK_PORCH    = V_BACK_PORCH_DEF,
  parameter bit          SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF,
  parameter int unsigned SYNC_DELAY      = 1,
  parameter int unsigned FRAME_BITS      = 5,
  localparam int unsigned H_TOTAL = total4(H_PIXELS, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH),
  localparam int unsigned V_TOTAL = total4(V_PIXELS, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH),
  localparam int unsigned PIXEL_X_BITS = cnt_bits(H_TOTAL),
  localparam int unsigned PIXEL_Y_BITS = cnt_bits(V_TOTAL)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  output logic [PIXEL_X_BITS-1:0] pixel_x_o,
  output logic [PIXEL_Y_BITS-1:0] pixel_y_o,
  output logic                    active_o,
  output logic                    line_start_o,
  output logic                    frame_start_o,
  output logic [FRAME_BITS-1:0]   frame_counter_o,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    de_o
);

  if (SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing: SYNC_DELAY must be in 0..4");
  end
  if (H_PIXELS == 0 || H_FRONT_PORCH == 0 || H_SYNC_PULSE == 0 || H_BACK_PORCH == 0 ||
      V_PIXELS == 0 || V_FRONT_PORCH == 0 || V_SYNC_PULSE == 0 || V_BACK_PORCH == 0) begin : g_bad_timing
    $error("vga_timing: every H/V timing parameter must be non-zero");
  end
  if (FRAME_BITS < 1) begin : g_bad_frame
    $error("vga_timing: FRAME_BITS must be at least 1");
  end

  localparam logic [PIXEL_X_BITS-1:0] X_LAST   = PIXEL_X_BITS'(H_TOTAL - 1);
  localparam logic [PIXEL_Y_BITS-1:0] Y_LAST   = PIXEL_Y_BITS'(V_TOTAL - 1);
  localparam logic [PIXEL_X_BITS-1:0] X_VIS    = PIXEL_X_BITS'(H_PIXELS);
  localparam logic [PIXEL_X_BITS-1:0] X_HS_BEG = PIXEL_X_BITS'(H_PIXELS + H_FRONT_PORCH);
  localparam logic [PIXEL_X_BITS-1:0] X_HS_END = PIXEL_X_BITS'(H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [PIXEL_Y_BITS-1:0] Y_VIS    = PIXEL_Y_BITS'(V_PIXELS);
  localparam logic [PIXEL_Y_BITS-1:0] Y_VS_BEG = PIXEL_Y_BITS'(V_PIXELS + V_FRONT_PORCH);
  localparam logic [PIXEL_Y_BITS-1:0] Y_VS_END = PIXEL_Y_BITS'(V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE);

  logic [PIXEL_X_BITS-1:0] x_q, x_d;
  logic [PIXEL_Y_BITS-1:0] y_q, y_d;
  logic [FRAME_BITS-1:0]   fc_q, fc_d;
  logic                    x_wrap, y_wrap;
  logic                    hs_raw, vs_raw, act_raw;
  sync_t                   sync_raw, sync_dly;

  always_comb begin
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
    x_d    = x_wrap ? '0 : x_q + PIXEL_X_BITS'(1);
    y_d    = y_q;
    fc_d   = fc_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + PIXEL_Y_BITS'(1);
      // Frame count ticks on the same edge that returns the raster to (0,0).
      if (y_wrap) fc_d = fc_q + FRAME_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else if (ce_i) begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  assign hs_raw  = (x_q >= X_HS_BEG) && (x_q < X_HS_END);
  assign vs_raw  = (y_q >= Y_VS_BEG) && (y_q < Y_VS_END);
  assign act_raw = (x_q < X_VIS) && (y_q < Y_VIS);

  always_comb begin
    sync_raw.hsync = hs_raw ^ SYNC_ACTIVE_LOW;
    sync_raw.vsync = vs_raw ^ SYNC_ACTIVE_LOW;
    sync_raw.de    = act_raw;
  end

  vga_sync_delay #(
    .DEPTH          (SYNC_DELAY),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .ce_i (ce_i),
    .d_i  (sync_raw),
    .q_o  (sync_dly)
  );

  assign pixel_x_o       = x_q;
  assign pixel_y_o       = y_q;
  assign active_o        = act_raw;
  assign line_start_o    = ce_i && (x_q == '0);
  assign frame_start_o   = ce_i && (x_q == '0) && (y_q == '0);
  assign frame_counter_o = fc_q;
  assign hsync_o         = sync_dly.hsync;
  assign vsync_o         = sync_dly.vsync;
  assign de_o            = sync_dly.de;

endmodule

// File: tb/tb_vga_timing.sv
// Five vga_timing configurations on shared clk/rst/ce, each compared every cycle
// against an arithmetic raster model driven by the number of ce steps since reset.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  // Default timing, three delay depths.
  logic [9:0] a_x, b_x, c_x;
  logic [9:0] a_y, b_y, c_y;
  logic [4:0] a_fc, b_fc, c_fc;
  logic a_act, a_ls, a_fs, a_hs, a_vs, a_de;
  logic b_act, b_ls, b_fs, b_hs, b_vs, b_de;
  logic c_act, c_ls, c_fs, c_hs, c_vs, c_de;
  // Tiny timing, active-high sync.
  logic [2:0] s_x, s_y;
  logic [1:0] s_fc;
  logic s_act, s_ls, s_fs, s_hs, s_vs, s_de;
  // Medium timing, max delay.
  logic [4:0] m_x;
  logic [3:0] m_y;
  logic [2:0] m_fc;
  logic m_act, m_ls, m_fs, m_hs, m_vs, m_de;

  vga_timing #(.SYNC_DELAY(1)) u_a (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .pixel_x_o(a_x), .pixel_y_o(a_y), .active_o(a_act),
    .line_start_o(a_ls), .frame_start_o(a_fs), .frame_counter_o(a_fc),
    .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de));

  vga_timing #(.SYNC_DELAY(0)) u_b (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .pixel_x_o(b_x), .pixel_y_o(b_y), .active_o(b_act),
    .line_start_o(b_ls), .frame_start_o(b_fs), .frame_counter_o(b_fc),
    .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de));

  vga_timing #(.SYNC_DELAY(3)) u_c (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .pixel_x_o(c_x), .pixel_y_o(c_y), .active_o(c_act),
    .line_start_o(c_ls), .frame_start_o(c_fs), .frame_counter_o(c_fc),
    .hsync_o(c_hs), .vsync_o(c_vs), .de_o(c_de));

  vga_timing #(
    .H_PIXELS(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
    .V_PIXELS(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .SYNC_ACTIVE_LOW(1'b0), .SYNC_DELAY(2), .FRAME_BITS(2)
  ) u_s (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .pixel_x_o(s_x), .pixel_y_o(s_y), .active_o(s_act),
    .line_start_o(s_ls), .frame_start_o(s_fs), .frame_counter_o(s_fc),
    .hsync_o(s_hs), .vsync_o(s_vs), .de_o(s_de));

  vga_timing #(
    .H_PIXELS(16), .H_FRONT_PORCH(4), .H_SYNC_PULSE(8), .H_BACK_PORCH(4),
    .V_PIXELS(8), .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
    .SYNC_ACTIVE_LOW(1'b1), .SYNC_DELAY(4), .FRAME_BITS(3)
  ) u_m (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .pixel_x_o(m_x), .pixel_y_o(m_y), .active_o(m_act),
    .line_start_o(m_ls), .frame_start_o(m_fs), .frame_counter_o(m_fc),
    .hsync_o(m_hs), .vsync_o(m_vs), .de_o(m_de));

  function automatic logic [63:0] pk(input int x, input int y, input int fc, input bit a,
                                     input bit ls, input bit fs, input bit hs, input bit vs,
                                     input bit de);
    return {16'(x), 16'(y), 16'(fc), 10'd0, a, ls, fs, hs, vs, de};
  endfunction

  // Raster position is step count modulo line/frame length; delayed outputs are the
  // decode of step n-dly, or idle while in reset / before dly steps have elapsed.
  function automatic logic [63:0] model(input int hp, input int hf, input int hsp, input int hb,
                                        input int vp, input int vf, input int vsp, input int vb,
                                        input int fb, input int dly, input bit al,
                                        input int steps, input bit cev, input bit r);
    int ht, vt, x, y, fc, m, xm, ym;
    bit a, ls, fs, h, v, d;
    ht = hp + hf + hsp + hb;
    vt = vp + vf + vsp + vb;
    x  = steps % ht;
    y  = (steps / ht) % vt;
    fc = (steps / (ht * vt)) % (1 << fb);
    a  = (x < hp) && (y < vp);
    ls = cev && (x == 0);
    fs = ls && (y == 0);
    if (r || steps < dly) begin
      h = al; v = al; d = 1'b0;
    end else begin
      m  = steps - dly;
      xm = m % ht;
      ym = (m / ht) % vt;
      h  = ((xm >= hp + hf) && (xm < hp + hf + hsp)) ^ al;
      v  = ((ym >= vp + vf) && (ym < vp + vf + vsp)) ^ al;
      d  = (xm < hp) && (ym < vp);
    end
    return pk(x, y, fc, a, ls, fs, h, v, d);
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("dflt_d1", pk(int'(a_x), int'(a_y), int'(a_fc), a_act, a_ls, a_fs, a_hs, a_vs, a_de),
        model(640, 16, 96, 48, 480, 10, 2, 33, 5, 1, 1'b1, n, ce, rst));
    cmp("dflt_d0", pk(int'(b_x), int'(b_y), int'(b_fc), b_act, b_ls, b_fs, b_hs, b_vs, b_de),
        model(640, 16, 96, 48, 480, 10, 2, 33, 5, 0, 1'b1, n, ce, rst));
    cmp("dflt_d3", pk(int'(c_x), int'(c_y), int'(c_fc), c_act, c_ls, c_fs, c_hs, c_vs, c_de),
        model(640, 16, 96, 48, 480, 10, 2, 33, 5, 3, 1'b1, n, ce, rst));
    cmp("small",   pk(int'(s_x), int'(s_y), int'(s_fc), s_act, s_ls, s_fs, s_hs, s_vs, s_de),
        model(4, 1, 2, 1, 3, 1, 1, 1, 2, 2, 1'b0, n, ce, rst));
    cmp("medium",  pk(int'(m_x), int'(m_y), int'(m_fc), m_act, m_ls, m_fs, m_hs, m_vs, m_de),
        model(16, 4, 8, 4, 8, 2, 2, 2, 3, 4, 1'b1, n, ce, rst));
  endtask

  task automatic cycle(input bit ce_v, input bit rst_v);
    @(negedge clk);
    ce  = ce_v;
    rst = rst_v;
    if (rst_v) n = 0;
    #1;
    check_all();
    @(posedge clk);
    if (ce_v && !rst_v) n++;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    ce  = 1'b0;
    #1;
    check_all();
    for (int i = 0; i < 4; i++) cycle(i[0], 1'b1);
    // Uninterrupted stepping: several tiny/medium frames, 2+ default lines.
    for (int i = 0; i < 1800; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) cycle(1'($urandom_range(0, 1)), 1'b0);
    // One step every other clk stretches every period by two.
    for (int i = 0; i < 1800; i++) cycle(i[0], 1'b0);

    // Walk to a point where the medium instance shows both delayed syncs asserted.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle(1'b1, 1'b0);
      #1;
      if (m_hs === 1'b0 && m_vs === 1'b0) found = 1'b1;
    end
    cmp("sync_window_reached", 64'(found), 64'd1);

    // Reset mid-cycle with ce low: idle levels must appear before any clk edge.
    @(negedge clk);
    ce = 1'b0;
    #2;
    rst = 1'b1;
    n   = 0;
    #1;
    check_all();
    cmp("async_rst_sync", {62'd0, m_hs, m_vs}, 64'd3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 600; i++) cycle(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Upstream stage of the pixel renderer: the single source of raster coordinates and sync for the VGA output path.
- Generates pixel_x/pixel_y counters, active-video flag, line/frame strobes and a frame counter for animation.
- Generates hsync/vsync/de delayed by a programmable number of pixel steps, so the sync edges line up with the renderer's registered colour output at the VGA PMOD.

Parameters:
- H_PIXELS, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_PIXELS, 480, visible lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0; 0 = sync pulses drive 1
- SYNC_DELAY, 1, pixel steps of delay on hsync/vsync/de relative to pixel_x/pixel_y (legal range 0..4)
- FRAME_BITS, 5, frame_counter width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  pixel step enable; tie to 1 for one pixel per clk
- pixel_x  out  PIXEL_X_BITS  current column, PIXEL_X_BITS = clog2(H_TOTAL)
- pixel_y  out  PIXEL_Y_BITS  current line, PIXEL_Y_BITS = clog2(V_TOTAL)
- active  out  1  undelayed: pixel_x < H_PIXELS and pixel_y < V_PIXELS
- line_start  out  1  strobe: pixel_x == 0 and ce
- frame_start  out  1  strobe: pixel_x == 0, pixel_y == 0 and ce
- frame_counter  out  FRAME_BITS  completed-frame count, modulo 2^FRAME_BITS
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- de  out  1  delayed active

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800 by default); V_TOTAL likewise (525 by default).
- Counter state advances only on clk edges with ce = 1. With ce = 0, all registers hold and all strobes are 0.
- pixel_x counts 0..H_TOTAL-1, then wraps to 0. On that wrap pixel_y increments.
- pixel_y counts 0..V_TOTAL-1, then wraps to 0 when pixel_x also wraps. frame_counter increments on that same edge and wraps 2^FRAME_BITS-1 -> 0 silently.
- Raw decodes, combinational from the counter registers:
  - hs_raw: H_PIXELS+H_FRONT_PORCH <= pixel_x < H_PIXELS+H_FRONT_PORCH+H_SYNC_PULSE (656..751 by default)
  - vs_raw: V_PIXELS+V_FRONT_PORCH <= pixel_y < V_PIXELS+V_FRONT_PORCH+V_SYNC_PULSE (490..491 by default)
  - active: as defined in Ports
- Output polarity: hsync = hs_raw XOR SYNC_ACTIVE_LOW; vsync the same. de is never inverted.
- Delay line: SYNC_DELAY stages; every stage shifts only on ce = 1.
  - SYNC_DELAY = 0: hsync/vsync/de follow the raw decodes with zero latency.
  - SYNC_DELAY = N: outputs equal the decodes of the counter value N pixel steps earlier.
- Reset (rst = 1, asynchronous): pixel_x = 0, pixel_y = 0, frame_counter = 0.
  - Every delay stage loads the inactive level: sync deasserted (1 when SYNC_ACTIVE_LOW), de = 0.
  - Consequence: hsync = vsync = 1 (default polarity) and de = 0 immediately, without a clock edge.
  - Reset asserted mid-line or mid-frame takes effect at once, regardless of ce. No partial pulse is emitted after release.
- After rst falls, the first ce = 1 cycle sees pixel_x = pixel_y = 0, so line_start = frame_start = 1.
- Strobes are combinational: one cycle wide per pixel step, not registered.
- Elaboration errors:
  - SYNC_DELAY > 4
  - any H/V parameter = 0
  - FRAME_BITS < 1

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL and width localparam functions
  - sync polarity constant
- The renderer reuses this package, so timing is defined in one place.
- One sub-module: vga_sync_delay, a parameterised 3-bit-wide, ce-gated shift register with an asynchronous inactive-level reset. With depth 0 it is a wire.

Test Plan:
- Default params, ce = 1, release rst -> hsync = 1, vsync = 1, de = 0 during reset. frame_start = 1 in the first cycle. Line period is 800 clk. With SYNC_DELAY = 1, hsync is low for 96 clk starting when pixel_x = 657 is presented.
- Default params, observe a full frame -> vsync is low exactly while the delayed pixel_y is 490..491. de is high on 640x480 = 307200 cycles per frame. Frame period is 420000 clk.
- Small params (H = 4/1/2/1, V = 3/1/1/1, FRAME_BITS = 2), 5 frames -> frame_counter sequence 0,1,2,3,0,1. Each increment lands on the same edge as the x/y wrap.
- ce toggling 1-of-2 -> every period doubles (line 1600 clk). Counters and outputs hold when ce = 0. line_start only occurs with ce = 1.
- SYNC_DELAY = 0 vs 3 run in lockstep -> the SYNC_DELAY = 3 outputs equal the SYNC_DELAY = 0 outputs exactly 3 ce-steps later. After reset the first 3 steps show inactive levels.
- Assert rst asynchronously at pixel_x = 700, pixel_y = 490 (both syncs active) -> hsync/vsync go to 1 and de goes to 0 before the next clk edge. After release, counting restarts at 0,0 with frame_counter = 0.
